// File: rtl/vga_draw_pkg.sv
// Shared types and defaults for the VGA drawing engines.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } draw_state_e;

  localparam int DEF_NX       = 10;
  localparam int DEF_NY       = 9;
  localparam int DEF_COLOR_W  = 9;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

endpackage

// File: rtl/vga_raster_counter.sv
// Raster-order X/Y stepper over a rectangle origin and extent.
// pos_x/pos_y give the position the owner should present after the coming clock edge.
module vga_raster_counter
  import vga_draw_pkg::*;
#(
  parameter int nX = DEF_NX,
  parameter int nY = DEF_NY
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [nX-1:0] org_x,
  input  logic [nY-1:0] org_y,
  input  logic [nX-1:0] ext_w,
  input  logic [nY-1:0] ext_h,
  output logic [nX:0]   pos_x,
  output logic [nY:0]   pos_y,
  output logic          last
);

  logic [nX-1:0] x0_r;
  logic [nX-1:0] wm1_r;
  logic [nY-1:0] hm1_r;
  logic [nX-1:0] col_r;
  logic [nY-1:0] row_r;
  logic [nX-1:0] nxt_col_s;
  logic [nY-1:0] nxt_row_s;
  logic [nX:0]   cur_x_r;
  logic [nY:0]   cur_y_r;

  // Iteration counts against w-1/h-1 decide the end, independent of screen coordinates.
  assign last = (col_r == wm1_r) && (row_r == hm1_r);

  // Next column/row and the matching absolute position (one spare bit so it never wraps).
  always_comb begin
    nxt_col_s = col_r;
    nxt_row_s = row_r;
    pos_x     = cur_x_r;
    pos_y     = cur_y_r;
    if (load) begin
      nxt_col_s = {nX{1'b0}};
      nxt_row_s = {nY{1'b0}};
      pos_x     = {1'b0, org_x};
      pos_y     = {1'b0, org_y};
    end else if (step) begin
      if (col_r == wm1_r) begin
        nxt_col_s = {nX{1'b0}};
        nxt_row_s = row_r + nY'(1'b1);
        pos_x     = {1'b0, x0_r};
        pos_y     = cur_y_r + (nY+1)'(1'b1);
      end else begin
        nxt_col_s = col_r + nX'(1'b1);
        pos_x     = cur_x_r + (nX+1)'(1'b1);
      end
    end else begin
      nxt_col_s = col_r;
    end
  end

  // Counter and extent registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x0_r    <= {nX{1'b0}};
      wm1_r   <= {nX{1'b0}};
      hm1_r   <= {nY{1'b0}};
      col_r   <= {nX{1'b0}};
      row_r   <= {nY{1'b0}};
      cur_x_r <= {(nX+1){1'b0}};
      cur_y_r <= {(nY+1){1'b0}};
    end else begin
      col_r   <= nxt_col_s;
      row_r   <= nxt_row_s;
      cur_x_r <= pos_x;
      cur_y_r <= pos_y;
      if (load) begin
        x0_r  <= org_x;
        wm1_r <= ext_w - nX'(1'b1);
        hm1_r <= ext_h - nY'(1'b1);
      end else begin
        x0_r  <= x0_r;
        wm1_r <= wm1_r;
        hm1_r <= hm1_r;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine feeding the vga_adapter pixel-write port, one pixel per clock.
// Optional off-screen write suppression: define VGA_RECT_CLIP_EN.
module vga_rect_fill
  import vga_draw_pkg::*;
#(
  parameter int nX       = DEF_NX,
  parameter int nY       = DEF_NY,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [nX-1:0]      cmd_x0,
  input  logic [nY-1:0]      cmd_y0,
  input  logic [nX-1:0]      cmd_w,
  input  logic [nY-1:0]      cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [nX-1:0]      x,
  output logic [nY-1:0]      y,
  output logic [COLOR_W-1:0] color,
  output logic               write,
  output logic               busy,
  output logic               done
);

`ifdef VGA_RECT_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif
  localparam logic [nX:0] SCREEN_W_L = (nX+1)'(SCREEN_W);
  localparam logic [nY:0] SCREEN_H_L = (nY+1)'(SCREEN_H);

  draw_state_e        state_r;
  draw_state_e        next_state_s;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic               zero_size_s;
  logic               on_screen_s;
  logic               write_nxt_s;
  logic [nX:0]        pos_x_s;
  logic [nY:0]        pos_y_s;
  logic [nX-1:0]      x_r;
  logic [nY-1:0]      y_r;
  logic [COLOR_W-1:0] color_r;
  logic               write_r;
  logic               busy_r;
  logic               done_r;

  vga_raster_counter #(
    .nX(nX),
    .nY(nY)
  ) u_raster (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .step  (step_s),
    .org_x (cmd_x0),
    .org_y (cmd_y0),
    .ext_w (cmd_w),
    .ext_h (cmd_h),
    .pos_x (pos_x_s),
    .pos_y (pos_y_s),
    .last  (last_s)
  );

  assign zero_size_s = (cmd_w == {nX{1'b0}}) || (cmd_h == {nY{1'b0}});
  assign on_screen_s = (pos_x_s < SCREEN_W_L) && (pos_y_s < SCREEN_H_L);
  // Without clipping every pixel writes and the coordinate simply truncates (wraps).
  assign write_nxt_s = (next_state_s == ST_DRAW) && (on_screen_s || !CLIP_EN);
  assign cmd_ready   = (state_r == ST_IDLE);

  assign x     = x_r;
  assign y     = y_r;
  assign color = color_r;
  assign write = write_r;
  assign busy  = busy_r;
  assign done  = done_r;

  // Next-state and counter control.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_s = 1'b1;
          if (zero_size_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_DRAW;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (last_s) begin
          next_state_s = ST_DONE;
        end else begin
          step_s = 1'b1;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and registered adapter/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      x_r     <= {nX{1'b0}};
      y_r     <= {nY{1'b0}};
      color_r <= {COLOR_W{1'b0}};
      write_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      x_r     <= pos_x_s[nX-1:0];
      y_r     <= pos_y_s[nY-1:0];
      write_r <= write_nxt_s;
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (next_state_s == ST_DONE);
      if (load_s) begin
        color_r <= cmd_color;
      end else begin
        color_r <= color_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed table, hand sequences, random commands.
module tb_vga_rect_fill;

  localparam int NX = 10;
  localparam int NY = 9;
  localparam int CW = 9;
`ifdef VGA_RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [NX-1:0] cmd_x0 = '0;
  logic [NY-1:0] cmd_y0 = '0;
  logic [NX-1:0] cmd_w = '0;
  logic [NY-1:0] cmd_h = '0;
  logic [CW-1:0] cmd_color = '0;
  logic [NX-1:0] x;
  logic [NY-1:0] y;
  logic [CW-1:0] color;
  logic          write, busy, done;

  always #5 clock = ~clock;

  vga_rect_fill dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .x(x), .y(y), .color(color), .write(write), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit wr; int x; int y; int col; bit dn; bit bsy; bit rdy;
  } cyc_t;
  cyc_t exp_q[$];

  typedef struct {
    string name; int x0; int y0; int w; int h; int col;
    int n_wr; int done_cyc; int fx; int fy; int lx; int ly;
  } vec_t;
  vec_t tbl[9];

  int cyc_idx, n_wr, done_at, fx, fy, lx, ly;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference: a rectangle is w*h pixels in raster order, then one done cycle.
  task automatic model_cmd(int x0, int y0, int w, int h, int col);
    cyc_t c;
    int px, py;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        px = x0 + k;
        py = y0 + r;
        c.wr  = !CLIP || (px < 640 && py < 480);
        c.x   = px % (1 << NX);
        c.y   = py % (1 << NY);
        c.col = col;
        c.dn  = 1'b0; c.bsy = 1'b1; c.rdy = 1'b0;
        exp_q.push_back(c);
      end
    end
    c = '{wr: 1'b0, x: 0, y: 0, col: 0, dn: 1'b1, bsy: 1'b1, rdy: 1'b0};
    exp_q.push_back(c);
  endtask

  task automatic model_idle();
    cyc_t c;
    c = '{wr: 1'b0, x: 0, y: 0, col: 0, dn: 1'b0, bsy: 1'b0, rdy: 1'b1};
    exp_q.push_back(c);
  endtask

  task automatic clear_stats();
    cyc_idx = 0; n_wr = 0; done_at = -1; fx = -1; fy = -1; lx = -1; ly = -1;
  endtask

  task automatic check_next(string tag);
    cyc_t e;
    bit ok;
    logic [NX-1:0] ex;
    logic [NY-1:0] ey;
    logic [CW-1:0] ec;
    @(negedge clock);
    cyc_idx++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected cycle left at cycle %0d", tag, cyc_idx);
      return;
    end
    e  = exp_q.pop_front();
    ex = e.x[NX-1:0];
    ey = e.y[NY-1:0];
    ec = e.col[CW-1:0];
    ok = (write === e.wr) && (done === e.dn) && (busy === e.bsy) && (cmd_ready === e.rdy);
    if (e.wr) ok = ok && (x === ex) && (y === ey) && (color === ec);
    if (!ok) begin
      errors++;
      $display("FAIL %s cyc %0d: got wr=%b x=%0d y=%0d col=%h dn=%b bsy=%b rdy=%b, want wr=%b x=%0d y=%0d col=%h dn=%b bsy=%b rdy=%b",
               tag, cyc_idx, write, x, y, color, done, busy, cmd_ready,
               e.wr, ex, ey, ec, e.dn, e.bsy, e.rdy);
    end
    if (write === 1'b1) begin
      if (n_wr == 0) begin fx = int'(x); fy = int'(y); end
      lx = int'(x); ly = int'(y);
      n_wr++;
    end
    if (done === 1'b1 && done_at < 0) done_at = cyc_idx;
  endtask

  task automatic drive_cmd(int x0, int y0, int w, int h, int col);
    cmd_x0 = x0[NX-1:0]; cmd_y0 = y0[NY-1:0];
    cmd_w = w[NX-1:0]; cmd_h = h[NY-1:0]; cmd_color = col[CW-1:0];
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge while idle: handshake, then follow the whole command.
  task automatic run_cmd(string tag, int x0, int y0, int w, int h, int col);
    clear_stats();
    chk({tag, "_ready_before"}, int'(cmd_ready), 1);
    drive_cmd(x0, y0, w, h, col);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    model_cmd(x0, y0, w, h, col);
    model_idle();
    while (exp_q.size() > 0) check_next(tag);
  endtask

  initial begin
    tbl[0] = '{"rect3x2", 5, 7, 3, 2, 'h1C0, 6, 7, 5, 7, 7, 8};
    tbl[1] = '{"zero_w", 10, 10, 0, 4, 'h1FF, 0, 1, -1, -1, -1, -1};
    tbl[2] = '{"zero_h", 3, 3, 5, 0, 'h007, 0, 1, -1, -1, -1, -1};
    tbl[3] = '{"one_px", 0, 0, 1, 1, 'h001, 1, 2, 0, 0, 0, 0};
    tbl[5] = '{"corner", 630, 470, 10, 10, 'h124, 100, 101, 630, 470, 639, 479};
    tbl[8] = '{"big", 100, 200, 40, 30, 'h0F0, 1200, 1201, 100, 200, 139, 229};
    if (CLIP) begin
      tbl[4] = '{"clip4x1", 638, 100, 4, 1, 'h03F, 2, 5, 638, 100, 639, 100};
      tbl[6] = '{"ywrap", 1020, 510, 2, 3, 'h0AA, 0, 7, -1, -1, -1, -1};
      tbl[7] = '{"xwrap", 1000, 20, 50, 1, 'h155, 0, 51, -1, -1, -1, -1};
    end else begin
      tbl[4] = '{"clip4x1", 638, 100, 4, 1, 'h03F, 4, 5, 638, 100, 641, 100};
      tbl[6] = '{"ywrap", 1020, 510, 2, 3, 'h0AA, 6, 7, 1020, 510, 1021, 0};
      tbl[7] = '{"xwrap", 1000, 20, 50, 1, 'h155, 50, 51, 1000, 20, 25, 20};
    end

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_outputs", int'({x, y, color, write, busy, done}), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].name, tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col);
      chk({tbl[i].name, "_nwr"}, n_wr, tbl[i].n_wr);
      chk({tbl[i].name, "_done"}, done_at, tbl[i].done_cyc);
      if (tbl[i].n_wr > 0) begin
        chk({tbl[i].name, "_first"}, fx * 1000 + fy, tbl[i].fx * 1000 + tbl[i].fy);
        chk({tbl[i].name, "_last"}, lx * 1000 + ly, tbl[i].lx * 1000 + tbl[i].ly);
      end
    end

    // Reset in the middle of a 10x10 fill, after pixel 37.
    clear_stats();
    drive_cmd(50, 60, 10, 10, 'h0F0);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    model_cmd(50, 60, 10, 10, 'h0F0);
    for (int i = 0; i < 37; i++) check_next("pre_reset");
    reset = 1'b1;
    #1;
    chk("midrst_outputs", int'({x, y, color, write, busy, done}), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    run_cmd("after_rst", 5, 7, 3, 2, 'h1C0);
    chk("after_rst_nwr", n_wr, 6);
    chk("after_rst_done", done_at, 7);

    // cmd_valid held high; fields change mid-draw; second command waits for ready.
    clear_stats();
    drive_cmd(1, 1, 2, 2, 'h0AA);
    @(posedge clock);
    model_cmd(1, 1, 2, 2, 'h0AA);
    model_idle();
    model_cmd(20, 30, 3, 1, 'h155);
    model_idle();
    check_next("held");
    check_next("held");
    drive_cmd(20, 30, 3, 1, 'h155);
    while (exp_q.size() > 0) begin
      check_next("held");
      if (cyc_idx == 7) cmd_valid = 1'b0;
    end
    chk("held_nwr", n_wr, 7);
    chk("held_last", lx * 1000 + ly, 22 * 1000 + 30);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_cmd("rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 511)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
